accumulator_writeback: RTL
==========================

# accumulator_writeback

Drains finished result rows from the accumulator back into the unified buffer. This closes the loop opposite `systolic_data_staging`, which moves data from the unified buffer into the MAC array. On a start command it reads N consecutive accumulator rows and requantizes each 32-bit lane to 16 bits (optional ReLU, rounding shift, saturation). It then writes the rows to consecutive unified-buffer addresses and pulses done. It sits between `accumulator` (`data_o`) and `unified_buffer` (`unified_buffer_in`, write port), and is commanded by `control_unit`.

## Interface
Parameters:
- LANES, 32, row width in lanes
- ACC_W, 32, accumulator lane width
- OUT_W, 16, unified-buffer lane width
- ACC_AW, 7, accumulator address width
- UB_AW, 12, unified-buffer address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-low
- start_i  in  1  command strobe, sampled only in IDLE
- acc_start_addr_i  in  ACC_AW  first accumulator row
- ub_start_addr_i  in  UB_AW  first unified-buffer row
- num_rows_i  in  ACC_AW+1  row count, 0..128
- relu_en_i  in  1  clamp negatives to 0 before shifting
- shift_i  in  5  arithmetic right shift, 0..31
- acc_rd_en_o  out  1  accumulator read enable
- acc_addr_rd_o  out  ACC_AW  accumulator read address
- acc_data_i  in  ACC_W x LANES  accumulator row, valid 1 cycle after read enable
- ub_write_o  out  1  unified-buffer write enable
- ub_addr_wr_o  out  UB_AW  unified-buffer write address
- ub_data_o  out  OUT_W x LANES  requantized row
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse

## Operation
- **States:**
  - IDLE: wait for start_i. On start_i with num_rows_i>0, go to ISSUE; with num_rows_i=0, go to DONE.
  - ISSUE: issue one read per cycle. After the Nth read, go to DRAIN.
  - DRAIN: 2 cycles, then DONE.
  - DONE: 1 cycle, then IDLE.
- **Command latching:** all command inputs (addresses, count, relu_en_i, shift_i) are latched on the accepted start edge. Later changes to these inputs have no effect on the transfer.
- **Ignored starts:** start_i outside IDLE, including the DONE cycle, is ignored with no side effects.
- **Address generation:** row i reads accumulator address (acc_start + i) mod 128 and writes unified-buffer address (ub_start + i) mod 4096. Both wrap silently.
- **Per-lane requantization** (signed arithmetic, 33-bit intermediate):
  1. x = acc lane; if relu_en and x<0, x=0.
  2. If shift>0, x = (x + 2^(shift-1)) >>> shift (round half up).
  3. Saturate to [-32768, 32767].
- **Read protocol:** the accumulator is read at most once per row. Read enable and address are deasserted/held outside ISSUE.

## Timing
- **Start cycle S:** the cycle in which start_i is accepted in IDLE.
- **Reads:** acc_rd_en_o=1 in cycles S+1..S+N, with address acc_start+(k-1) in cycle S+k.
- **Accumulator data:** acc_data_i for row k is valid in cycle S+k+1. It is requantized combinationally and registered.
- **Writes:** ub_write_o=1 in cycles S+3..S+N+2, with matching address and data. Latency from read to write is 2 cycles; throughput is 1 row/cycle.
- **busy_o:** 1 in cycles S+1..S+N+2.
- **done_o:** pulses in cycle S+N+3.
- **N=0:** no reads and no writes; busy_o stays 0; done_o pulses at S+1.
- **Back-to-back:** the next start is accepted at S+N+4 at the earliest (IDLE again).
- **Reset values:** all outputs reset to 0 (enables, addresses, data, busy_o, done_o); state resets to IDLE.
- **Reset mid-transfer:** rst_i=0 on any edge aborts the transfer. In-flight rows are dropped, no further writes occur, and no done_o pulse is produced.

## Structure
- **Shared package** (`packages.sv`):
  - enum `wb_state_t` {IDLE, ISSUE, DRAIN, DONE}
  - constants for LANES, ACC_W, OUT_W
- **Sub-module `wb_requant`:** one lane, purely combinational ReLU/round/saturate, instantiated LANES times via generate.
- **Top level:** the FSM, row counters, address registers and the output register stage.

## Test plan
- **Basic transfer:** acc_start=5, ub_start=100, N=4, relu=0, shift=0, lanes hold small values (e.g. lane j = 10·row+j).
  - Reads at addresses 5..8 in cycles S+1..S+4.
  - Writes at UB addresses 100..103 in cycles S+3..S+6, data unchanged.
  - done_o at S+7.
- **Requantization:** shift=4, relu=1, lanes {-50, 24, 23, 0x7FFFFFFF, 8}.
  - Outputs {0, 2, 1, 32767, 1}.
  - With relu=0: -50 gives -3, and 0x80000000 saturates to -32768.
- **Wrap-around:** acc_start=126, ub_start=4094, N=4.
  - Read addresses 126, 127, 0, 1.
  - Write addresses 4094, 4095, 0, 1.
- **Edge commands:**
  - N=0: done_o at S+1, no enables asserted.
  - N=128: 128 contiguous writes, done_o at S+131.
  - start_i held high during the transfer: exactly one transfer occurs.
- **Reset mid-operation:** rst_i=0 at S+3 of an N=8 transfer.
  - All outputs 0 on the next edge.
  - No done_o; a new start after reset transfers correctly.

Source files
------------

// File: rtl/accumulator_writeback_pkg.sv
// accumulator_writeback_pkg
// Shared types and default dimensions for the accumulator write-back path.
// Contents:
//   WB_* localparams -- default row geometry and address widths
//   wb_state_t       -- write-back sequencer states
package accumulator_writeback_pkg;

   localparam int unsigned WB_LANES  = 32;
   localparam int unsigned WB_ACC_W  = 32;
   localparam int unsigned WB_OUT_W  = 16;
   localparam int unsigned WB_ACC_AW = 7;
   localparam int unsigned WB_UB_AW  = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } wb_state_t;

endpackage

// File: rtl/accumulator_writeback_requant.sv
// accumulator_writeback_requant
// One-lane combinational requantizer: optional ReLU, round-half-up
// arithmetic right shift, then saturation to the signed OUT_W range.
// Ports:
//   acc_i      in  ACC_W  signed accumulator lane
//   relu_en_i  in  1      clamp negatives to zero before shifting
//   shift_i    in  5      right shift amount 0..31
//   data_o     out OUT_W  requantized, saturated lane
module accumulator_writeback_requant
   import accumulator_writeback_pkg::*;
#(
   parameter int unsigned ACC_W = WB_ACC_W,
   parameter int unsigned OUT_W = WB_OUT_W
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic             relu_en_i,
   input  logic [4:0]       shift_i,
   output logic [OUT_W-1:0] data_o
);

   // One guard bit so adding the rounding bias can never overflow.
   localparam int unsigned EXT_W = ACC_W + 1;
   localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(64'sd1 <<< (OUT_W - 1)));
   localparam logic signed [EXT_W-1:0] EXT_ONE = EXT_W'(64'sd1);

   logic signed [EXT_W-1:0] ext_s;
   logic signed [EXT_W-1:0] bias_s;
   logic signed [EXT_W-1:0] rnd_s;

   // ReLU, rounding shift and saturation of a single lane.
   always_comb begin
      if (relu_en_i && acc_i[ACC_W-1]) begin
         ext_s = '0;
      end else begin
         ext_s = $signed({acc_i[ACC_W-1], acc_i});
      end

      // Adding half an LSB of the result before the shift gives round half up.
      if (shift_i != 5'd0) begin
         bias_s = EXT_ONE << (shift_i - 5'd1);
      end else begin
         bias_s = '0;
      end

      rnd_s = (ext_s + bias_s) >>> shift_i;

      if (rnd_s > SAT_MAX) begin
         data_o = SAT_MAX[OUT_W-1:0];
      end else if (rnd_s < SAT_MIN) begin
         data_o = SAT_MIN[OUT_W-1:0];
      end else begin
         data_o = rnd_s[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/accumulator_writeback.sv
// accumulator_writeback
// Reads N consecutive accumulator rows, requantizes every lane and writes
// the rows to consecutive unified-buffer addresses, then pulses done_o.
// Reads issue one per cycle; each row appears on the write port two cycles
// after its read. All outputs are registered.
// Ports:
//   clk_i, rst_i             clock, synchronous active-low reset
//   start_i                  command strobe (accepted only in IDLE)
//   acc_start_addr_i         first accumulator row
//   ub_start_addr_i          first unified-buffer row
//   num_rows_i               row count 0..2**ACC_AW
//   relu_en_i, shift_i       requantization controls
//   acc_rd_en_o/addr_rd_o    accumulator read port
//   acc_data_i               accumulator row, valid one cycle after read
//   ub_write_o/addr_wr_o     unified-buffer write port
//   ub_data_o                requantized row
//   busy_o, done_o           status
module accumulator_writeback
   import accumulator_writeback_pkg::*;
#(
   parameter int unsigned LANES  = WB_LANES,
   parameter int unsigned ACC_W  = WB_ACC_W,
   parameter int unsigned OUT_W  = WB_OUT_W,
   parameter int unsigned ACC_AW = WB_ACC_AW,
   parameter int unsigned UB_AW  = WB_UB_AW
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start_i,
   input  logic [ACC_AW-1:0]           acc_start_addr_i,
   input  logic [UB_AW-1:0]            ub_start_addr_i,
   input  logic [ACC_AW:0]             num_rows_i,
   input  logic                        relu_en_i,
   input  logic [4:0]                  shift_i,
   output logic                        acc_rd_en_o,
   output logic [ACC_AW-1:0]           acc_addr_rd_o,
   input  logic [LANES-1:0][ACC_W-1:0] acc_data_i,
   output logic                        ub_write_o,
   output logic [UB_AW-1:0]            ub_addr_wr_o,
   output logic [LANES-1:0][OUT_W-1:0] ub_data_o,
   output logic                        busy_o,
   output logic                        done_o
);

   localparam logic [ACC_AW-1:0] ACC_ONE = {{(ACC_AW-1){1'b0}}, 1'b1};
   localparam logic [UB_AW-1:0]  UB_ONE  = {{(UB_AW-1){1'b0}}, 1'b1};
   localparam logic [ACC_AW:0]   CNT_ONE = {{ACC_AW{1'b0}}, 1'b1};

   wb_state_t                   state_q,   state_d;
   logic [ACC_AW:0]             remain_q,  remain_d;   // reads still to issue after the current one
   logic                        drain_q,   drain_d;
   logic                        rd_en_q,   rd_en_d;
   logic [ACC_AW-1:0]           rd_addr_q, rd_addr_d;
   logic                        vld_q,     vld_d;      // acc_data_i carries a requested row this cycle
   logic [UB_AW-1:0]            wr_ptr_q,  wr_ptr_d;   // UB address for the next captured row
   logic                        relu_q,    relu_d;
   logic [4:0]                  shift_q,   shift_d;
   logic                        wr_en_q,   wr_en_d;
   logic [UB_AW-1:0]            wr_addr_q, wr_addr_d;
   logic [LANES-1:0][OUT_W-1:0] wr_data_q, wr_data_d;
   logic                        busy_q,    busy_d;
   logic                        done_q,    done_d;
   logic [LANES-1:0][OUT_W-1:0] req_s;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      accumulator_writeback_requant #(
         .ACC_W (ACC_W),
         .OUT_W (OUT_W)
      ) u_requant (
         .acc_i     (acc_data_i[g]),
         .relu_en_i (relu_q),
         .shift_i   (shift_q),
         .data_o    (req_s[g])
      );
   end

   // Next-state, read issue and write-stage capture logic.
   always_comb begin
      state_d   = state_q;
      remain_d  = remain_q;
      drain_d   = drain_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      vld_d     = rd_en_q;
      wr_ptr_d  = wr_ptr_q;
      relu_d    = relu_q;
      shift_d   = shift_q;
      wr_en_d   = vld_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      if (vld_q) begin
         wr_addr_d = wr_ptr_q;
         wr_ptr_d  = wr_ptr_q + UB_ONE;
         wr_data_d = req_s;
      end else begin
         wr_data_d = wr_data_q;
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               relu_d   = relu_en_i;
               shift_d  = shift_i;
               wr_ptr_d = ub_start_addr_i;
               if (num_rows_i != '0) begin
                  state_d   = ISSUE;
                  rd_en_d   = 1'b1;
                  rd_addr_d = acc_start_addr_i;
                  remain_d  = num_rows_i - CNT_ONE;
               end else begin
                  state_d   = DONE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (remain_q == '0) begin
               state_d = DRAIN;
               drain_d = 1'b0;
            end else begin
               rd_en_d   = 1'b1;
               rd_addr_d = rd_addr_q + ACC_ONE;
               remain_d  = remain_q - CNT_ONE;
            end
         end
         DRAIN: begin
            // Two cycles: last row's data cycle, then its write cycle.
            if (drain_q) begin
               state_d = DONE;
            end else begin
               drain_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == ISSUE) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         remain_q  <= '0;
         drain_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         vld_q     <= 1'b0;
         wr_ptr_q  <= '0;
         relu_q    <= 1'b0;
         shift_q   <= 5'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         remain_q  <= remain_d;
         drain_q   <= drain_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         vld_q     <= vld_d;
         wr_ptr_q  <= wr_ptr_d;
         relu_q    <= relu_d;
         shift_q   <= shift_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign acc_rd_en_o   = rd_en_q;
   assign acc_addr_rd_o = rd_addr_q;
   assign ub_write_o    = wr_en_q;
   assign ub_addr_wr_o  = wr_addr_q;
   assign ub_data_o     = wr_data_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;

endmodule
